if_fetch_unit: RTL

// - Instruction-fetch stage directly upstream of the instruction ROM: owns the PC, drives rom_en/rom_addr,

---
 rtl/if_fetch_unit_pkg.sv | 28 ++
 rtl/if_fetch_unit_if.sv | 32 +++
 rtl/if_fetch_unit_queue.sv | 80 ++++++++
 rtl/if_fetch_unit.sv | 97 +++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Purpose : core-wide constants and the fetch-entry layout shared by the IF and
//           ID stages (XLEN, reset PC default, NOP encoding, entry field offsets).
// Ports   : none (package).
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

   // Fetch entry: {pc, inst}, pc in the upper half
   localparam int unsigned FE_W        = 2 * XLEN;
   localparam int unsigned FE_INST_LSB = 0;
   localparam int unsigned FE_PC_LSB   = XLEN;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   // Clear the byte-offset bits so every PC is word aligned
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Purpose : bundles the fetch stage's ROM port, EX redirect and IF->ID stream.
// Signals : rom_en/rom_addr/rom_inst_i  - ROM request and same-cycle read data
//           redirect_i/redirect_pc_i    - branch/jump redirect from EX
//           if_valid_o/if_pc_o/if_inst_o/id_ready_i - valid/ready stream to ID
// Modports: master = fetch unit side, slave = ROM/EX/ID environment side.
// -----------------------------------------------------------------------------
interface if_fetch_unit_if;
   import if_fetch_unit_pkg::*;

   logic            rom_en;
   logic [XLEN-1:0] rom_addr;
   logic [XLEN-1:0] rom_inst_i;
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            if_valid_o;
   logic [XLEN-1:0] if_pc_o;
   logic [XLEN-1:0] if_inst_o;
   logic            id_ready_i;

   modport master (
      output rom_en, rom_addr, if_valid_o, if_pc_o, if_inst_o,
      input  rom_inst_i, redirect_i, redirect_pc_i, id_ready_i
   );

   modport slave (
      input  rom_en, rom_addr, if_valid_o, if_pc_o, if_inst_o,
      output rom_inst_i, redirect_i, redirect_pc_i, id_ready_i
   );

endinterface

// File: rtl/if_fetch_unit_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_queue
// Purpose : synchronous FIFO of fetch entries between the ROM and decode.
//           Flush clears it in one cycle; head is driven from registered state
//           and reads zero when empty.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           push_i/data_i - enqueue one entry
//           pop_i         - dequeue head (ignored when empty)
//           flush_i       - drop all entries (wins over push/pop)
//           head_o        - oldest entry, '0 when empty
//           valid_o       - queue not empty
//           full_o        - queue holds DEPTH entries
// -----------------------------------------------------------------------------
module if_fetch_unit_queue
   import if_fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic            flush_i,
   input  logic [FE_W-1:0] data_i,
   output logic [FE_W-1:0] head_o,
   output logic            valid_o,
   output logic            full_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [FE_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign valid_o = (count_q != '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

   // Pointer/count next state; a push into a full queue needs a same-cycle pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop_i & valid_o;
      do_push  = push_i & (~full_o | do_pop);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible while counted valid
   always_ff @(posedge clk) begin
      if (do_push && !flush_i && !rst) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Purpose : instruction-fetch stage. Owns the PC, requests the ROM, captures
//           the same-cycle ROM word and queues {pc, inst} for decode. Handles
//           decode back-pressure and EX redirects (redirect has top priority).
// Ports   : clk, rst  - clock, synchronous active-high reset
//           fe        - if_fetch_unit_if.master (ROM port, redirect, ID stream)
//           perf_fetch_cnt_o / perf_stall_cnt_o - only with IF_PERF_EN defined:
//                       pushes, and cycles with the queue full and no pop
// Config  : IF_PERF_EN adds the two performance counters.
// -----------------------------------------------------------------------------
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     FQ_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   if_fetch_unit_if.master  fe
`ifdef IF_PERF_EN
   ,
   output logic [31:0]      perf_fetch_cnt_o,
   output logic [31:0]      perf_stall_cnt_o
`endif
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            pop_c, push_c;
   logic            fq_valid, fq_full;
   logic [FE_W-1:0] fq_head;
   fetch_entry_t    fetch_entry;

   // Handshake: a full queue can still accept when the head leaves this cycle
   assign pop_c  = fq_valid & fe.id_ready_i;
   assign push_c = ~rst & ~fe.redirect_i & (~fq_full | pop_c);

   assign fe.rom_en   = push_c;
   assign fe.rom_addr = pc_q;

   assign fetch_entry.pc   = pc_q;
   assign fetch_entry.inst = fe.rom_inst_i;

   // PC: redirect target, else advance on each fetch (wraps modulo 2^XLEN)
   always_comb begin
      pc_d = pc_q;
      if (fe.redirect_i) begin
         pc_d = word_align(fe.redirect_pc_i);
      end else if (push_c) begin
         pc_d = pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= word_align(RESET_PC);
      else     pc_q <= pc_d;
   end

   // Redirect flushes the queue, discarding any head ID accepted that cycle
   if_fetch_unit_queue #(
      .DEPTH (FQ_DEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_c),
      .pop_i   (pop_c),
      .flush_i (fe.redirect_i),
      .data_i  (fetch_entry),
      .head_o  (fq_head),
      .valid_o (fq_valid),
      .full_o  (fq_full)
   );

   assign fe.if_valid_o = fq_valid;
   assign fe.if_pc_o    = fq_head[FE_PC_LSB +: XLEN];
   assign fe.if_inst_o  = fq_head[FE_INST_LSB +: XLEN];

`ifdef IF_PERF_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;

   // Counters survive redirects; only reset clears them
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_q + 32'(push_c);
         stall_cnt_q <= stall_cnt_q + 32'(fq_full & ~pop_c);
      end
   end

   assign perf_fetch_cnt_o = fetch_cnt_q;
   assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule
